// File: rtl/fifo_pkg.sv
// fifo_pkg: shared fifo types and constants for blocks wired around the fifo.
package fifo_pkg;
  localparam int fifo_occ_w = 2;
  typedef enum logic [fifo_occ_w-1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } fifo_state_e;
endpackage

// File: rtl/fifo_stream_out.sv
// fifo_stream_out: drains a fifo into a valid/ready stream through a main + skid register pair.
module fifo_stream_out
  import fifo_pkg::*;
#(
  parameter int data_width = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  fifo_empty,
  input  logic [data_width-1:0] fifo_read_data,
  output logic                  fifo_read_enable,
  output logic                  out_valid,
  output logic [data_width-1:0] out_data,
  input  logic                  out_ready,
  output logic [fifo_occ_w-1:0] occupancy
);
  fifo_state_e           state_q, state_d;
  logic [data_width-1:0] main_q, main_d, skid_q, skid_d;
  logic                  pop, xfer;
  assign pop  = fifo_read_enable;
  assign xfer = out_valid && out_ready;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= EMPTY;
    else          state_q <= state_d;
  end
  // Data registers carry no reset; they are only observed while out_valid is high.
  always_ff @(posedge clk) begin
    main_q <= main_d;
    skid_q <= skid_d;
  end
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        main_d  = pop ? fifo_read_data : main_q;
        state_d = pop ? ONE : EMPTY;
      end
      ONE: begin
        main_d  = (pop && xfer) ? fifo_read_data : main_q;
        skid_d  = (pop && !xfer) ? fifo_read_data : skid_q;
        state_d = (pop && !xfer) ? FULL : (xfer && !pop) ? EMPTY : ONE;
      end
      FULL: begin
        main_d  = xfer ? skid_q : main_q;
        state_d = xfer ? ONE : FULL;
      end
      default: state_d = EMPTY;
    endcase
  end
  always_comb begin
    out_valid        = state_q != EMPTY;
    occupancy        = fifo_occ_w'(state_q);
    out_data         = main_q;
    fifo_read_enable = reset_n && !fifo_empty && state_q != FULL;
  end
endmodule

// File: tb/tb_fifo_stream_out.sv
// tb_fifo_stream_out: directed and randomised checks of fifo_stream_out against a fifo model and scoreboard.
module tb_fifo_stream_out;
  logic        clk = 1'b0;
  logic        reset_n, fifo_empty, fifo_read_enable, out_valid, out_ready;
  logic [31:0] fifo_read_data, out_data;
  logic [1:0]  occupancy;
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] fq[$];
  logic [31:0] sb[$];
  always #5 clk = ~clk;
  fifo_stream_out #(.data_width(32)) dut (
    .clk(clk), .reset_n(reset_n), .fifo_empty(fifo_empty), .fifo_read_data(fifo_read_data),
    .fifo_read_enable(fifo_read_enable), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .occupancy(occupancy)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic drive_fifo();
    fifo_empty     = fq.size() == 0;
    fifo_read_data = fq.size() != 0 ? fq[0] : 32'h0;
  endtask
  // One clock: sample handshakes before the edge, then update the fifo model and scoreboard.
  task automatic tick();
    logic        p, x;
    logic [31:0] d, rd;
    #1;
    p  = fifo_read_enable;
    x  = out_valid && out_ready;
    d  = out_data;
    rd = fifo_read_data;
    if (fifo_empty) chk("no_pop_empty", 32'(p), 32'h0);
    @(posedge clk);
    #1;
    if (x) chk("order", d, sb.size() != 0 ? sb.pop_front() : ~d);
    if (p) begin
      void'(fq.pop_front());
      sb.push_back(rd);
    end
    drive_fifo();
    #1;
  endtask
  initial begin
    logic [31:0] s1[3];
    logic [31:0] s2[4];
    logic [1:0]  o2[4];
    logic        any;
    s1 = '{32'hA, 32'hB, 32'hC};
    s2 = '{32'h1, 32'h2, 32'h3, 32'h4};
    o2 = '{2'd2, 2'd1, 2'd1, 2'd1};
    reset_n   = 1'b0;
    out_ready = 1'b0;
    fq = '{32'hA, 32'hB, 32'hC};
    drive_fifo();
    #2;
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_occ", 32'(occupancy), 32'h0);
    chk("rst_re", 32'(fifo_read_enable), 32'h0);
    @(posedge clk);
    #1;
    chk("rst_hold_valid", 32'(out_valid), 32'h0);
    reset_n   = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("s1_first_re", 32'(fifo_read_enable), 32'h1);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("s1_data", out_data, s1[i]);
      chk("s1_occ", 32'(occupancy), 32'h1);
      chk("s1_valid", 32'(out_valid), 32'h1);
      tick();
    end
    chk("s1_drained", 32'(out_valid), 32'h0);
    chk("s1_occ0", 32'(occupancy), 32'h0);
    out_ready = 1'b0;
    fq = '{32'h1, 32'h2, 32'h3, 32'h4};
    drive_fifo();
    tick();
    tick();
    tick();
    chk("s2_occ2", 32'(occupancy), 32'h2);
    chk("s2_stable", out_data, 32'h1);
    chk("s2_re_low", 32'(fifo_read_enable), 32'h0);
    chk("s2_two_pops", 32'(fq.size()), 32'h2);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("s2_data", out_data, s2[i]);
      chk("s2_occ", 32'(occupancy), 32'(o2[i]));
      tick();
    end
    chk("s2_drained", 32'(out_valid), 32'h0);
    any = 1'b0;
    for (int i = 0; i < 6; i++) begin
      out_ready = 1'(i);
      #1;
      any = any | fifo_read_enable | out_valid;
      tick();
      any = any | fifo_read_enable | out_valid;
    end
    chk("s3_idle", 32'(any), 32'h0);
    out_ready = 1'b0;
    fq = '{32'h55};
    drive_fifo();
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("s4_valid", 32'(out_valid), 32'h1);
      chk("s4_data", out_data, 32'h55);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("s4_done", 32'(out_valid), 32'h0);
    out_ready = 1'b0;
    fq = '{32'h11, 32'h22, 32'h33};
    drive_fifo();
    tick();
    tick();
    chk("s5_occ2", 32'(occupancy), 32'h2);
    #2;
    reset_n = 1'b0;
    #1;
    chk("s5_valid", 32'(out_valid), 32'h0);
    chk("s5_re", 32'(fifo_read_enable), 32'h0);
    chk("s5_occ", 32'(occupancy), 32'h0);
    sb.delete();
    #1;
    reset_n = 1'b1;
    chk("s5_fifo_kept", 32'(fq.size()), 32'h1);
    out_ready = 1'b1;
    tick();
    chk("s5_next", out_data, 32'h33);
    chk("s5_next_valid", 32'(out_valid), 32'h1);
    tick();
    for (int i = 0; i < 10000; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) fq.push_back($urandom);
      drive_fifo();
      tick();
    end
    out_ready = 1'b1;
    repeat (fq.size() + 4) tick();
    chk("rnd_sb_empty", 32'(sb.size()), 32'h0);
    chk("rnd_fifo_empty", 32'(fq.size()), 32'h0);
    chk("rnd_idle", 32'(out_valid), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fifo_stream_out.md
FIFO_STREAM_OUT -- requirements
Module: fifo_stream_out

Interface
REQ-001 The block SHALL take parameter data_width, default 32, the payload width (matches the fifo it drains).
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-003 Port clk  input  1  sole clock; all state changes on rising edge.
REQ-004 Port reset_n  input  1  asynchronous active-low reset.
REQ-005 Port fifo_empty  input  1  fifo has no word at its head.
REQ-006 Port fifo_read_data  input  data_width  fifo head word; valid in the same cycle whenever fifo_empty is low.
REQ-007 Port fifo_read_enable  output  1  pops the fifo head at this rising edge.
REQ-008 Port out_valid  output  1  out_data holds a word for the downstream consumer.
REQ-009 Port out_data  output  data_width  word offered downstream.
REQ-010 Port out_ready  input  1  downstream accepts out_data this cycle.
REQ-011 Port occupancy  output  2  number of words buffered (0..2).

Function
REQ-012 The block SHALL hold a main register (drives out_data) and a skid register, with state EMPTY (0 words), ONE (main valid), or FULL (main and skid valid).
REQ-013 out_valid SHALL be high exactly in ONE or FULL; occupancy SHALL equal 0/1/2 for EMPTY/ONE/FULL, all driven from registers.
REQ-014 fifo_read_enable SHALL equal reset_n && !fifo_empty && state != FULL, with no combinational path from out_ready.
REQ-015 A pop is fifo_read_enable high at a rising edge; a transfer is out_valid && out_ready high at a rising edge.
REQ-016 EMPTY, pop: main <= fifo_read_data, go to ONE.
REQ-017 ONE, pop and transfer: main <= fifo_read_data, stay ONE.
REQ-018 ONE, pop without transfer: skid <= fifo_read_data, go to FULL.
REQ-019 ONE, transfer without pop: go to EMPTY.
REQ-020 FULL, transfer: main <= skid, go to ONE; no pop occurs in FULL.
REQ-021 All other cases SHALL hold state and both registers.
REQ-022 A word popped at edge N SHALL appear on out_data after edge N when main was empty or transferring; latency is one cycle.
REQ-023 With fifo non-empty and out_ready held high, the block SHALL sustain one transfer per cycle.
REQ-024 Words SHALL leave in pop order, with no loss or duplication.
REQ-025 While out_valid && !out_ready, out_data SHALL stay stable.
REQ-026 out_valid SHALL not drop until a transfer occurs.
REQ-027 fifo_empty going high SHALL stop pops in the same cycle; buffered words SHALL still drain.
REQ-028 If out_ready is asserted while out_valid is low, it SHALL have no effect.

Reset
REQ-029 reset_n low SHALL immediately force state EMPTY, out_valid 0, occupancy 0, and fifo_read_enable 0, independent of clk.
REQ-030 Reset mid-operation SHALL discard buffered words; fifo words not yet popped are untouched.
REQ-031 Data registers need no reset value; out_data is don't-care while out_valid is low.
REQ-032 The first pop after reset deassertion SHALL occur at the first rising edge with fifo_empty low.

Structure
REQ-033 The three-state enum type SHALL live in the shared fifo_pkg package, alongside any fifo-related constants.
REQ-034 The block SHALL be a single module with no sub-modules, instantiated next to fifo and wired to its empty/read_data/read_enable.

Verification
REQ-035 Scenario: reset, fifo holds 0xA,0xB,0xC, out_ready=1 -> out_data 0xA,0xB,0xC on three consecutive cycles starting one cycle after the first pop; occupancy 1 throughout.
REQ-036 Scenario: fifo holds 0x1..0x4, out_ready=0 -> exactly two pops, occupancy 2, out_data=0x1 stable, fifo_read_enable low; then out_ready=1 -> 0x1,0x2,0x3,0x4 in order.
REQ-037 Scenario: fifo empty, out_ready toggling -> fifo_read_enable never high, out_valid never high.
REQ-038 Scenario: single word 0x55 with out_ready=0 for 5 cycles -> out_valid held, out_data=0x55 all 5 cycles, one transfer when ready rises.
REQ-039 Scenario: occupancy 2, reset_n pulsed low between clock edges -> out_valid and fifo_read_enable drop immediately, occupancy 0; after release, next fifo word is popped.
REQ-040 Scenario: random out_ready and fifo fill over 10k cycles -> scoreboard shows in-order, lossless delivery and no pop while fifo_empty is high.
